// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker FSM state codes, polynomial taps and the step function.
// Latency: n/a (types and pure functions). Backpressure: n/a.
`timescale 1ns/1ps
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [7:0] ERR_SAT = 8'hFF;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        logic fb;
        fb = ^(s & LFSR_TAPS);
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Combinational next-state of the 16-bit Fibonacci LFSR, shared with the upstream generator.
// Latency: 0 cycles. Backpressure: none; the caller decides when to register the result.
`timescale 1ns/1ps
module lfsr16_step
    import lfsr_pkg::*;
(
    input  logic [15:0] cur_state,
    output logic [15:0] nxt_state
);

    assign nxt_state = lfsr16_next(cur_state);

endmodule

// File: rtl/lfsr_pass_checker.sv
// Checks an LFSR word stream: seeds from the first word, declares pass after PASS_COUNT matches in a row, fail at ERR_LIMIT mismatches.
// Latency: verdict registered on the accepting edge, gpio_out_pass visible 1 cycle after accept.
// Backpressure: in_ready high in IDLE/SYNC/CHECK, low in DONE. Macro LFSR_PASS_CHECKER_HEARTBEAT_EN adds the LED heartbeat.
`timescale 1ns/1ps
module lfsr_pass_checker
    import lfsr_pkg::*;
#(
    parameter int PASS_COUNT = 1024,
    parameter int ERR_LIMIT  = 4,
    parameter int LED_DIV_W  = 24
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        gpio_out_pass,
    output logic        led,
    output logic [7:0]  err_count,
    output logic [1:0]  chk_state
);

    localparam int              MCW      = $clog2(PASS_COUNT + 1);
    localparam logic [MCW-1:0]  PASS_TGT = MCW'(PASS_COUNT);

    if (LED_DIV_W < 3) begin : g_bad_div
        $error("LED_DIV_W must be at least 3");
    end

    chk_state_t     state, state_nxt;
    logic [15:0]    expected, expected_nxt;
    logic [MCW-1:0] match_cnt, match_cnt_nxt;
    logic [7:0]     err_cnt, err_cnt_nxt;
    logic           pass_q, pass_nxt;

    logic           accept;
    logic           word_match;
    logic           limit_hit;
    logic           count_hit;
    logic [15:0]    step_in;
    logic [15:0]    step_out;

    assign in_ready   = (state != ST_DONE);
    assign accept     = in_valid && in_ready;
    assign word_match = (in_data == expected);

    // SYNC steps the incoming seed; CHECK steps the running expectation.
    assign step_in = (state == ST_SYNC) ? in_data : expected;

    lfsr16_step u_step (
        .cur_state (step_in),
        .nxt_state (step_out)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            expected  <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            pass_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            expected  <= expected_nxt;
            match_cnt <= match_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            pass_q    <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        expected_nxt  = expected;
        match_cnt_nxt = match_cnt;
        err_cnt_nxt   = err_cnt;
        pass_nxt      = pass_q;
        limit_hit     = 1'b0;
        count_hit     = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_SYNC;
            end

            ST_SYNC: begin
                if (accept) begin
                    expected_nxt  = step_out;
                    match_cnt_nxt = '0;
                    state_nxt     = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (accept) begin
                    expected_nxt = step_out;
                    if (word_match) begin
                        match_cnt_nxt = match_cnt + MCW'(1);
                        count_hit     = (match_cnt_nxt == PASS_TGT);
                    end else begin
                        match_cnt_nxt = '0;
                        if (err_cnt != ERR_SAT) begin
                            err_cnt_nxt = err_cnt + 8'd1;
                        end
                        limit_hit = (int'(err_cnt_nxt) >= ERR_LIMIT);
                    end

                    // Fail outranks pass if both ever land on the same word.
                    if (limit_hit) begin
                        state_nxt = ST_DONE;
                        pass_nxt  = 1'b0;
                    end else if (count_hit) begin
                        state_nxt = ST_DONE;
                        pass_nxt  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_nxt = ST_DONE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gpio_out_pass = pass_q;
    assign err_count     = err_cnt;
    assign chk_state     = state;

`ifdef LFSR_PASS_CHECKER_HEARTBEAT_EN
    logic [LED_DIV_W-1:0] div_q;
    logic                 led_c;

    // Free-running divider; its wrap is invisible to the FSM.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + LED_DIV_W'(1);
        end
    end

    always_comb begin
        led_c = 1'b0;
        case (state)
            ST_SYNC, ST_CHECK: led_c = div_q[LED_DIV_W-1];
            ST_DONE:           led_c = pass_q ? 1'b1 : div_q[LED_DIV_W-3];
            default:           led_c = 1'b0;
        endcase
    end

    assign led = led_c;
`else
    assign led = pass_q;
`endif

endmodule

// File: tb/tb_lfsr_pass_checker.sv
// Self-checking bench for lfsr_pass_checker: table vectors plus scripted pass/fail/reset runs through a scoreboard queue.
`timescale 1ns/1ps
module tb_lfsr_pass_checker;

    localparam int PASS_N = 1024;
    localparam int ERR_N  = 4;
    localparam int DIV_W  = 8;

    // Compared vector: {chk_state[12:11], err_count[10:3], gpio_out_pass[2], led[1], in_ready[0]}
`ifdef LFSR_PASS_CHECKER_HEARTBEAT_EN
    localparam logic [12:0] CMP_MASK = 13'h1FFD;
`else
    localparam logic [12:0] CMP_MASK = 13'h1FFF;
`endif

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        gpio_out_pass;
    logic        led;
    logic [7:0]  err_count;
    logic [1:0]  chk_state;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [15:0] cur;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [1:0]  st;
        logic [7:0]  err;
        logic        pass;
    } vec_t;

    vec_t tbl[7];

    lfsr_pass_checker #(
        .PASS_COUNT (PASS_N),
        .ERR_LIMIT  (ERR_N),
        .LED_DIV_W  (DIV_W)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .gpio_out_pass (gpio_out_pass),
        .led           (led),
        .err_count     (err_count),
        .chk_state     (chk_state)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] tb_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [12:0] mk(input logic [1:0] st, input logic [7:0] err, input logic pass);
        return {st, err, pass, pass, (st != 2'd3)};
    endfunction

    task automatic check_vec(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {chk_state, err_count, gpio_out_pass, led, in_ready};
        checks++;
        if ((act & CMP_MASK) !== (exp & CMP_MASK)) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (st,err,pass,led,rdy)", name, act & CMP_MASK, exp & CMP_MASK);
        end
    endtask

    // Called at posedge+1: drive, push the expectation, clock, pop and compare.
    task automatic drive_and_check(input string name, input logic v, input logic [15:0] d, input logic [12:0] exp);
        in_valid = v;
        in_data  = d;
        exp_q.push_back(exp);
        @(posedge sys_clk);
        #1;
        check_vec(name, exp_q.pop_front());
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        sys_rst_n = 1'b0;
        #2;
        check_vec("async_reset", mk(2'd0, 8'd0, 1'b0));
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        drive_and_check("idle_to_sync", 1'b0, 16'h0000, mk(2'd1, 8'd0, 1'b0));
    endtask

    task automatic seed(input logic [15:0] s);
        cur = s;
        drive_and_check("seed", 1'b1, s, mk(2'd2, 8'd0, 1'b0));
    endtask

    task automatic run_good(input string name, input int n, input logic [7:0] err, input bit pass_at_end);
        for (int i = 1; i <= n; i++) begin
            cur = tb_step(cur);
            drive_and_check(name, 1'b1, cur,
                (pass_at_end && i == n) ? mk(2'd3, err, 1'b1) : mk(2'd2, err, 1'b0));
        end
    endtask

    task automatic send_bad(input string name, input logic [7:0] err_after);
        cur = tb_step(cur);
        drive_and_check(name, 1'b1, cur ^ 16'h8001,
            (int'(err_after) >= ERR_N) ? mk(2'd3, err_after, 1'b0) : mk(2'd2, err_after, 1'b0));
    endtask

    task automatic hold_done(input string name, input logic [7:0] err, input logic pass);
        for (int i = 0; i < 3; i++) begin
            drive_and_check(name, 1'b1, tb_step(cur), mk(2'd3, err, pass));
        end
    endtask

`ifdef LFSR_PASS_CHECKER_HEARTBEAT_EN
    task automatic check_blink(input string name, input int want_toggles, input bit want_level);
        int   toggles;
        logic prev;
        toggles = 0;
        prev    = led;
        for (int i = 0; i < 128; i++) begin
            @(posedge sys_clk);
            #1;
            if (led !== prev) toggles++;
            prev = led;
        end
        checks++;
        if (toggles != want_toggles || (want_toggles == 0 && led !== want_level)) begin
            errors++;
            $display("FAIL %s led toggles=%0d level=%b required toggles=%0d", name, toggles, led, want_toggles);
        end
    endtask
`endif

    initial begin
        int accepted;

        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        cur       = 16'h0000;

        tbl[0] = '{1'b1, 16'hACE1, 2'd2, 8'd0, 1'b0};
        tbl[1] = '{1'b1, 16'h0000, 2'd2, 8'd1, 1'b0};
        tbl[2] = '{1'b1, 16'hAB38, 2'd2, 8'd1, 1'b0};
        tbl[3] = '{1'b0, 16'hFFFF, 2'd2, 8'd1, 1'b0};
        tbl[4] = '{1'b1, 16'h559C, 2'd2, 8'd1, 1'b0};
        tbl[5] = '{1'b1, 16'hFFFF, 2'd2, 8'd2, 1'b0};
        tbl[6] = '{1'b1, 16'h1567, 2'd2, 8'd2, 1'b0};

        #1;
        // Full pass from seed 0xACE1 (first checked word 0x5670)
        apply_reset();
        seed(16'hACE1);
        run_good("pass_1024", PASS_N, 8'd0, 1'b1);
        hold_done("pass_hold", 8'd0, 1'b1);
`ifdef LFSR_PASS_CHECKER_HEARTBEAT_EN
        check_blink("led_pass_steady", 0, 1'b1);
`endif

        // Mismatch then recovery: expectation keeps stepping through bad words
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive_and_check($sformatf("tbl_%0d", i), tbl[i].v, tbl[i].d, mk(tbl[i].st, tbl[i].err, tbl[i].pass));
        end

        // Four corrupted words scattered among good ones
        apply_reset();
        seed(16'hACE1);
        accepted = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2 || i == 5 || i == 7 || i == 10) begin
                accepted++;
                send_bad("scatter_bad", 8'(accepted));
            end else begin
                run_good("scatter_good", 1, 8'(accepted), 1'b0);
            end
        end
        hold_done("fail_hold", 8'd4, 1'b0);
`ifdef LFSR_PASS_CHECKER_HEARTBEAT_EN
        check_blink("led_fail_blink", 4, 1'b0);
`endif

        // Random 50% valid gaps: pass on exactly the 1024th accepted match
        apply_reset();
        seed(16'hACE1);
        accepted = 0;
        for (int it = 0; it < 6000 && accepted < PASS_N; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                cur = tb_step(cur);
                accepted++;
                drive_and_check("gaps", 1'b1, cur,
                    (accepted == PASS_N) ? mk(2'd3, 8'd0, 1'b1) : mk(2'd2, 8'd0, 1'b0));
            end else begin
                drive_and_check("gaps_idle", 1'b0, 16'($urandom), mk(2'd2, 8'd0, 1'b0));
            end
        end
        checks++;
        if (accepted != PASS_N) begin
            errors++;
            $display("FAIL gaps_budget accepted=%0d required=%0d", accepted, PASS_N);
        end
        hold_done("gaps_hold", 8'd0, 1'b1);

        // Reset mid-check after 500 matches, then re-seed with 0x1234
        apply_reset();
        seed(16'hACE1);
        run_good("pre_reset", 500, 8'd0, 1'b0);
        apply_reset();
        seed(16'h1234);
        run_good("reseed_pass", PASS_N, 8'd0, 1'b1);

        // Three early errors, 1023 matches, then the 4th error: fail wins
        apply_reset();
        seed(16'hACE1);
        send_bad("late_bad1", 8'd1);
        send_bad("late_bad2", 8'd2);
        send_bad("late_bad3", 8'd3);
        run_good("late_1023", PASS_N - 1, 8'd3, 1'b0);
        send_bad("late_bad4", 8'd4);
        hold_done("late_fail_hold", 8'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
